csr_rmw_seq: RTL and testbench

//  Multi-cycle sequencer for Zicsr instructions (CSRRW/S/C and immediate forms).

---
 rtl/csr_rmw_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_csr_rmw_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_rmw_seq.sv
// csr_rmw_seq: read -> modify -> write sequencer for the Zicsr instructions.
// Reads the CSR, borrows the shared ALU for the set/clear/write arithmetic,
// writes the result back and hands the old CSR value to the integer register
// file. Every strobe and mux select is a flop loaded from the state being
// entered. The only combinational gating on the outputs is flush, which must
// be able to cancel a write in the same cycle it is raised.
module csr_rmw_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rd_idx,
    input  logic            flush,
    output logic            csr_re,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] csr_operand,
    output logic [1:0]      asel,
    output logic [1:0]      bsel,
    output logic [1:0]      alu_op,
    input  logic [XLEN-1:0] alu_res,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            rd_we,
    output logic [4:0]      rd_waddr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            done,
    output logic            illegal
);

    // funct3[1:0] selects the operation; funct3[2] selects the immediate form.
    localparam logic [1:0] KIND_ILL = 2'b00;
    localparam logic [1:0] KIND_RW  = 2'b01;
    localparam logic [1:0] KIND_RS  = 2'b10;

    // Operand mux and ALU encodings.
    localparam logic [1:0] ASEL_ZERO = 2'b00;
    localparam logic [1:0] ASEL_CSR  = 2'b11;
    localparam logic [1:0] BSEL_ZERO = 2'b00;
    localparam logic [1:0] BSEL_REG  = 2'b01;
    localparam logic [1:0] BSEL_IMM  = 2'b10;
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_OR     = 2'b01;
    localparam logic [1:0] OP_ANDN   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_READ   = 2'b01,
        S_MODIFY = 2'b10,
        S_WRITE  = 2'b11
    } state_t;

    // A CSR is written unless this is a set/clear whose source is x0 or uimm=0.
    function automatic logic wen_of(input logic [1:0] kind, input logic [4:0] rs1);
        return (kind == KIND_RW) || (rs1 != 5'd0);
    endfunction

    // A CSR is read unless this is a write-only swap whose result goes to x0.
    function automatic logic ren_of(input logic [1:0] kind, input logic [4:0] rd);
        return (rd != 5'd0) || (kind != KIND_RW);
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        fn_q, fn_d;
    logic [11:0]       addr_q, addr_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              csr_re_q, csr_re_d;
    logic [1:0]        asel_q, asel_d;
    logic [1:0]        bsel_q, bsel_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic              csr_we_q, csr_we_d;
    logic              rd_we_q, rd_we_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;

    // Decode of the request presented on the input ports.
    logic [1:0]        req_kind;
    logic              req_wen;
    logic              req_ren;
    logic              req_read_only;
    logic              req_illegal;
    logic              accept;

    // Controls derived from the latched instruction.
    logic [1:0]        cur_kind;
    logic              cur_wen;
    logic              cur_ren;

    // Decode the incoming request and decide whether it is taken this cycle.
    always_comb begin
        req_kind      = funct3[1:0];
        req_wen       = wen_of(req_kind, rs1_idx);
        req_ren       = ren_of(req_kind, rd_idx);
        req_read_only = (csr_addr[11:10] == 2'b11);
        req_illegal   = (req_kind == KIND_ILL) || (req_read_only && req_wen);
        accept        = (state_q == S_IDLE) && req_valid && !flush;
        cur_kind      = fn_q[1:0];
        cur_wen       = wen_of(cur_kind, rs1_q);
        cur_ren       = ren_of(cur_kind, rd_q);
    end

    // Next-state and next-output logic. Strobes default to zero every cycle so
    // each one is high only in the single state that owns it.
    always_comb begin
        state_d   = state_q;
        fn_d      = fn_q;
        addr_d    = addr_q;
        rs1_d     = rs1_q;
        rd_d      = rd_q;
        old_d     = old_q;
        wdata_d   = wdata_q;
        csr_re_d  = 1'b0;
        asel_d    = ASEL_ZERO;
        bsel_d    = BSEL_ZERO;
        alu_op_d  = OP_ADD;
        csr_we_d  = 1'b0;
        rd_we_d   = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    fn_d   = funct3;
                    addr_d = csr_addr;
                    rs1_d  = rs1_idx;
                    rd_d   = rd_idx;
                    if (req_illegal) begin
                        // Rejected before any CSR access is made.
                        illegal_d = 1'b1;
                    end else begin
                        state_d  = S_READ;
                        csr_re_d = req_ren;
                    end
                end
            end

            S_READ: begin
                // Skipped reads leave a clean zero rather than bus garbage.
                old_d   = cur_ren ? csr_rdata : '0;
                state_d = S_MODIFY;
                // A plain write passes the source through as 0 + src.
                asel_d  = (cur_kind == KIND_RW) ? ASEL_ZERO : ASEL_CSR;
                bsel_d  = fn_q[2] ? BSEL_IMM : BSEL_REG;
                case (cur_kind)
                    KIND_RW: alu_op_d = OP_ADD;
                    KIND_RS: alu_op_d = OP_OR;
                    default: alu_op_d = OP_ANDN;
                endcase
            end

            S_MODIFY: begin
                wdata_d  = alu_res;
                state_d  = S_WRITE;
                csr_we_d = cur_wen;
                rd_we_d  = (rd_q != 5'd0);
                done_d   = 1'b1;
            end

            S_WRITE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A trap or redirect abandons the operation before any later strobe.
        if (flush && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            csr_re_d = 1'b0;
            asel_d   = ASEL_ZERO;
            bsel_d   = BSEL_ZERO;
            alu_op_d = OP_ADD;
            csr_we_d = 1'b0;
            rd_we_d  = 1'b0;
            done_d   = 1'b0;
        end
    end

    // Sequencer state, latched instruction fields and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            fn_q      <= '0;
            addr_q    <= '0;
            rs1_q     <= '0;
            rd_q      <= '0;
            old_q     <= '0;
            wdata_q   <= '0;
            csr_re_q  <= 1'b0;
            asel_q    <= ASEL_ZERO;
            bsel_q    <= BSEL_ZERO;
            alu_op_q  <= OP_ADD;
            csr_we_q  <= 1'b0;
            rd_we_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fn_q      <= fn_d;
            addr_q    <= addr_d;
            rs1_q     <= rs1_d;
            rd_q      <= rd_d;
            old_q     <= old_d;
            wdata_q   <= wdata_d;
            csr_re_q  <= csr_re_d;
            asel_q    <= asel_d;
            bsel_q    <= bsel_d;
            alu_op_q  <= alu_op_d;
            csr_we_q  <= csr_we_d;
            rd_we_q   <= rd_we_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Output drive. Write-side strobes are masked by a same-cycle flush.
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        csr_re      = csr_re_q;
        csr_raddr   = addr_q;
        csr_operand = old_q;
        asel        = asel_q;
        bsel        = bsel_q;
        alu_op      = alu_op_q;
        csr_we      = csr_we_q && !flush;
        csr_waddr   = addr_q;
        csr_wdata   = wdata_q;
        rd_we       = rd_we_q && !flush;
        rd_waddr    = rd_q;
        rd_wdata    = old_q;
        done        = done_q && !flush;
        illegal     = illegal_q;
    end

endmodule

// File: tb/tb_csr_rmw_seq.sv
// Testbench for csr_rmw_seq. The bench plays the core: it holds the
// instruction, supplies the operand mux sources and ALU, and models the CSR
// file. Expected results come from the Zicsr rules applied to that model.
module tb_csr_rmw_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = '0;
    logic [11:0] csr_addr = '0;
    logic [4:0]  rs1_idx = '0;
    logic [4:0]  rd_idx = '0;
    logic        flush = 1'b0;
    logic        csr_re;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic [63:0] csr_operand;
    logic [1:0]  asel, bsel, alu_op;
    logic [63:0] alu_res;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        rd_we;
    logic [4:0]  rd_waddr;
    logic [63:0] rd_wdata;
    logic        done;
    logic        illegal;

    // Core-side operand sources.
    logic [63:0] reg1_val = '0, reg2_val = '0, pc_val = '0, imm_val = '0;
    logic [63:0] op_a, op_b;

    // Model state: CSR file and integer register file contents.
    logic [63:0] csr_mem [0:4095];
    logic [63:0] xreg [0:31];

    int n_checks = 0;
    int n_fail = 0;
    int n_ops = 0;

    // Observations from the most recent transaction.
    logic [63:0] last_we_data, last_rd_data;
    int          last_we_cnt, last_re_cnt, last_rdwe_cnt, last_done_cnt, last_done_cyc, last_ill_cnt;

    csr_rmw_seq #(.XLEN(64)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rd_idx(rd_idx),
        .flush(flush), .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_operand(csr_operand), .asel(asel), .bsel(bsel), .alu_op(alu_op),
        .alu_res(alu_res), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .done(done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // CSR file read port; a distinctive junk value when not strobed.
    assign csr_rdata = csr_re ? csr_mem[csr_raddr] : 64'hDEAD_BEEF_0BAD_F00D;

    // Shared operand muxes and ALU of the core.
    always_comb begin
        op_a = '0;
        op_b = '0;
        alu_res = '0;
        case (asel)
            2'b00:   op_a = 64'd0;
            2'b01:   op_a = reg1_val;
            2'b10:   op_a = pc_val;
            default: op_a = csr_operand;
        endcase
        case (bsel)
            2'b00:   op_b = 64'd0;
            2'b01:   op_b = reg2_val;
            2'b10:   op_b = imm_val;
            default: op_b = 64'h5A5A_5A5A_5A5A_5A5A;
        endcase
        case (alu_op)
            2'b00:   alu_res = op_a + op_b;
            2'b01:   alu_res = op_a | op_b;
            2'b10:   alu_res = op_a & ~op_b;
            default: alu_res = op_a ^ op_b;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Issue one instruction, watch five cycles, compare against the Zicsr rules.
    task automatic run_op(input logic [2:0] fn, input logic [11:0] addr,
                          input logic [4:0] rs1, input logic [4:0] rd, input int flush_at);
        logic [1:0]  kind;
        logic        exp_wen, exp_ren, exp_ill, flushed;
        logic [63:0] src, exp_old, exp_new;
        int          re_cnt = 0, we_cnt = 0, rdwe_cnt = 0, done_cnt = 0, ill_cnt = 0;
        int          done_cyc = 0, ill_cyc = 0, bad_mux = 0;
        logic [11:0] re_addr = '0, we_addr = '0;
        logic [4:0]  rdw_addr = '0;
        logic [63:0] we_data = '0, rd_data = '0, opnd = '0;
        logic        ready_obs [1:5];

        kind    = fn[1:0];
        src     = fn[2] ? {59'd0, rs1} : xreg[rs1];
        exp_wen = (kind == 2'b01) || (rs1 != 5'd0);
        exp_ren = (rd != 5'd0) || (kind != 2'b01);
        exp_ill = (kind == 2'b00) || ((addr[11:10] == 2'b11) && exp_wen);
        exp_old = exp_ren ? csr_mem[addr] : 64'd0;
        case (kind)
            2'b01:   exp_new = src;
            2'b10:   exp_new = exp_old | src;
            default: exp_new = exp_old & ~src;
        endcase
        flushed = !exp_ill && (flush_at >= 1) && (flush_at <= 3);

        @(negedge clk);
        check("ready_before", req_ready, 1'b1);
        req_valid = 1'b1;
        funct3    = fn;
        csr_addr  = addr;
        rs1_idx   = rs1;
        rd_idx    = rd;
        reg1_val  = rand64();
        pc_val    = rand64();
        reg2_val  = xreg[rs1];
        imm_val   = {59'd0, rs1};
        @(posedge clk);
        #1 req_valid = 1'b0;

        for (int k = 1; k <= 5; k++) begin
            flush = (k == flush_at);
            @(negedge clk);
            ready_obs[k] = req_ready;
            if (csr_re) begin re_cnt++; re_addr = csr_raddr; end
            if (csr_we) begin we_cnt++; we_addr = csr_waddr; we_data = csr_wdata; end
            if (rd_we) begin rdwe_cnt++; rdw_addr = rd_waddr; rd_data = rd_wdata; end
            if (done) begin done_cnt++; done_cyc = k; end
            if (illegal) begin ill_cnt++; ill_cyc = k; end
            if (k == 2) opnd = csr_operand;
            if ((k != 2) && ((asel != 2'b00) || (bsel != 2'b00) || (alu_op != 2'b00))) bad_mux++;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;

        check("mux_idle_zero", bad_mux, 0);
        if (exp_ill) begin
            check("ill_cnt", ill_cnt, 1);
            check("ill_cyc", ill_cyc, 1);
            check("ill_re", re_cnt, 0);
            check("ill_we", we_cnt, 0);
            check("ill_rdwe", rdwe_cnt, 0);
            check("ill_done", done_cnt, 0);
            check("ill_ready", ready_obs[1], 1'b1);
        end else if (flushed) begin
            check("fl_we", we_cnt, 0);
            check("fl_rdwe", rdwe_cnt, 0);
            check("fl_done", done_cnt, 0);
            check("fl_ill", ill_cnt, 0);
            check("fl_ready", ready_obs[flush_at + 1], 1'b1);
        end else begin
            check("done_cnt", done_cnt, 1);
            check("done_cyc", done_cyc, 3);
            check("ill_none", ill_cnt, 0);
            check("re_cnt", re_cnt, exp_ren ? 1 : 0);
            if (exp_ren) check("re_addr", re_addr, addr);
            check("operand", opnd, exp_old);
            check("we_cnt", we_cnt, exp_wen ? 1 : 0);
            if (exp_wen) begin
                check("we_addr", we_addr, addr);
                check("we_data", we_data, exp_new);
                csr_mem[addr] = exp_new;
            end
            check("rdwe_cnt", rdwe_cnt, (rd != 5'd0) ? 1 : 0);
            if (rd != 5'd0) begin
                check("rd_addr", rdw_addr, rd);
                check("rd_data", rd_data, exp_old);
            end
            check("busy_ready", {ready_obs[1], ready_obs[2], ready_obs[3], ready_obs[4]}, 4'b0001);
        end

        last_we_data  = we_data;
        last_rd_data  = rd_data;
        last_we_cnt   = we_cnt;
        last_re_cnt   = re_cnt;
        last_rdwe_cnt = rdwe_cnt;
        last_done_cnt = done_cnt;
        last_done_cyc = done_cyc;
        last_ill_cnt  = ill_cnt;
        n_ops++;
        $display("op %0d fn=%b addr=%h rs1=%0d rd=%0d flush_at=%0d illegal=%0d we=%0d rd_we=%0d done=%0d",
                 n_ops, fn, addr, rs1, rd, flush_at, ill_cnt, we_cnt, rdwe_cnt, done_cnt);
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [11:0] addr_tab [0:5];
    int          bad;

    initial begin
        addr_tab[0] = 12'h340; addr_tab[1] = 12'h300; addr_tab[2] = 12'h305;
        addr_tab[3] = 12'hC00; addr_tab[4] = 12'hC01; addr_tab[5] = 12'h7C0;
        for (int i = 0; i < 4096; i++) csr_mem[i] = rand64();
        xreg[0] = 64'd0;
        for (int i = 1; i < 32; i++) xreg[i] = rand64();

        // Reset state
        #3 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_strobes", {csr_re, csr_we, rd_we, done, illegal}, 5'b0);
        check("rst_mux", {asel, bsel, alu_op}, 6'b0);
        check("rst_operand", csr_operand, 64'd0);
        check("rst_wdata", csr_wdata, 64'd0);
        check("rst_rdwdata", rd_wdata, 64'd0);
        rstn = 1'b1;

        // CSRRW x5, mscratch, x6
        csr_mem[12'h340] = 64'hAA;
        xreg[6] = 64'h55;
        run_op(3'b001, 12'h340, 5'd6, 5'd5, 0);
        check("t_rw_wdata", last_we_data, 64'h55);
        check("t_rw_rdata", last_rd_data, 64'hAA);
        check("t_rw_cycle", last_done_cyc, 3);

        // CSRRS x7, mstatus, x0: read only
        csr_mem[12'h300] = 64'h8000_0000_0000_1888;
        run_op(3'b010, 12'h300, 5'd0, 5'd7, 0);
        check("t_rs0_we", last_we_cnt, 0);
        check("t_rs0_rd", last_rd_data, 64'h8000_0000_0000_1888);

        // CSRRCI uimm=3 on 0xF
        csr_mem[12'h305] = 64'hF;
        run_op(3'b111, 12'h305, 5'd3, 5'd8, 0);
        check("t_rci_wdata", last_we_data, 64'hC);

        // CSRRW with rd=x0: no read, no rd write
        run_op(3'b001, 12'h340, 5'd9, 5'd0, 0);
        check("t_rwx0_re", last_re_cnt, 0);
        check("t_rwx0_rdwe", last_rdwe_cnt, 0);
        check("t_rwx0_we", last_we_cnt, 1);

        // funct3=100
        run_op(3'b100, 12'h340, 5'd6, 5'd5, 0);
        check("t_f100_ill", last_ill_cnt, 1);

        // Read-only CSR
        csr_mem[12'hC00] = 64'h1234;
        run_op(3'b001, 12'hC00, 5'd6, 5'd5, 0);
        check("t_ro_ill", last_ill_cnt, 1);
        check("t_ro_we", last_we_cnt, 0);
        run_op(3'b010, 12'hC00, 5'd0, 5'd10, 0);
        check("t_ro_rd_ill", last_ill_cnt, 0);
        check("t_ro_rd_data", last_rd_data, 64'h1234);

        // Flush in MODIFY, then in WRITE
        run_op(3'b001, 12'h340, 5'd6, 5'd5, 2);
        check("t_flm_done", last_done_cnt, 0);
        run_op(3'b001, 12'h340, 5'd6, 5'd5, 3);
        check("t_flw_we", last_we_cnt, 0);

        // Flush in IDLE: request not taken
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1;
        funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd6; rd_idx = 5'd5;
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("t_idlefl_ready", req_ready, 1'b1);
        check("t_idlefl_strobes", {csr_re, illegal}, 2'b00);
        @(negedge clk);
        check("t_idlefl_write", {csr_we, rd_we, done}, 3'b000);

        // Async reset in READ
        csr_mem[12'h340] = 64'hCAFE;
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd6; rd_idx = 5'd5;
        reg2_val = xreg[6];
        @(posedge clk);
        #2 req_valid = 1'b0;
        check("t_rst_inread", csr_re, 1'b1);
        rstn = 1'b0;
        #1;
        check("t_rst_async_re", csr_re, 1'b0);
        check("t_rst_async_ready", req_ready, 1'b1);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (csr_we || rd_we || done) bad++;
        end
        rstn = 1'b1;
        check("t_rst_nowrite", bad, 0);
        run_op(3'b010, 12'h340, 5'd0, 5'd7, 0);
        check("t_rst_after", last_rd_data, 64'hCAFE);

        // Randomized operations
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  fn;
            logic [4:0]  r1, rdi;
            int          fa;
            fn  = 3'($urandom_range(0, 7));
            r1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdi = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            fa  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(fn, addr_tab[$urandom_range(0, 5)], r1, rdi, fa);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
